// File: rtl/writeback_stage_aligned_pkg.sv
// Shared encodings for the writeback stage: opcodes, load widths, immediate
// types, register index type and the writeback fault causes.
package writeback_stage_aligned_pkg;

  typedef enum logic [4:0] {
    OPCODE_NOP   = 5'h00,
    OPCODE_LOAD  = 5'h01,
    OPCODE_STORE = 5'h02,
    OPCODE_LOADI = 5'h03,
    OPCODE_ADD   = 5'h04,
    OPCODE_SUB   = 5'h05,
    OPCODE_JUMP  = 5'h06
  } t_opcode;

  localparam logic [1:0] CW_BYTE = 2'd0;
  localparam logic [1:0] CW_WORD = 2'd1;
  localparam logic [1:0] CW_LONG = 2'd2;

  typedef enum logic [1:0] {
    IT_UNSIGNED = 2'd0,
    IT_SIGNED   = 2'd1,
    IT_TOP      = 2'd2,
    IT_RESERVED = 2'd3
  } t_immediate_type;

  typedef logic [3:0] t_reg;

  typedef enum logic [1:0] {
    WB_FAULT_NONE       = 2'd0,
    WB_FAULT_MISALIGNED = 2'd1,
    WB_FAULT_TIMEOUT    = 2'd2,
    WB_FAULT_BAD_IMM    = 2'd3
  } t_wb_fault;

  typedef enum logic {
    ST_RUN       = 1'b0,
    ST_WAIT_DATA = 1'b1
  } t_wb_state;

  localparam logic [31:0] NOP_INSTRUCTION = {OPCODE_NOP, 27'h0};

  // The reserved encoding never reaches here with write enabled; it yields 0.
  function automatic logic [31:0] resolve_immediate(input logic [1:0] it,
                                                    input logic [15:0] imm);
    logic [31:0] value;
    case (t_immediate_type'(it))
      IT_UNSIGNED: value = {16'h0000, imm};
      IT_SIGNED:   value = {{16{imm[15]}}, imm};
      IT_TOP:      value = {imm, 16'h0000};
      default:     value = 32'h0;
    endcase
    return value;
  endfunction

endpackage

// File: rtl/writeback_stage_aligned_align.sv
// Combinational load lane select, sign/zero extension and misalign detection,
// shared with the forwarding logic.
module load_align_extend
  import writeback_stage_aligned_pkg::*;
#(
  parameter int ALIGN_LOADS = 1
) (
  input  logic [31:0] data_i,
  input  logic [1:0]  width_i,
  input  logic        signed_i,
  input  logic [1:0]  byte_offset_i,
  output logic [31:0] value_o,
  output logic        misaligned_o
);

  logic [1:0]  off;
  logic [31:0] shifted;

  always_comb begin
    off          = (ALIGN_LOADS != 0) ? byte_offset_i : 2'd0;
    shifted      = data_i >> {off, 3'b000};
    value_o      = shifted;
    misaligned_o = 1'b0;
    case (width_i)
      CW_BYTE: begin
        value_o = signed_i ? {{24{shifted[7]}}, shifted[7:0]} : {24'h0, shifted[7:0]};
      end
      CW_WORD: begin
        value_o      = signed_i ? {{16{shifted[15]}}, shifted[15:0]} : {16'h0, shifted[15:0]};
        misaligned_o = off[0];
      end
      // LONG and the undefined width encoding both take the full word.
      default: begin
        value_o      = data_i;
        misaligned_o = (off != 2'd0);
      end
    endcase
  end

endmodule

// File: rtl/writeback_stage_aligned.sv
// Writeback register stage: resolves LOADI immediates, aligns sub-word loads,
// waits (with timeout) for slow memory data and reports precise faults.
module writeback_stage_aligned
  import writeback_stage_aligned_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 255,
  parameter int TIMEOUT_WIDTH  = 8,
  parameter int ALIGN_LOADS    = 1
) (
  input  logic        clock_i,
  input  logic        reset_ni,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] inbound_instruction_i,
  input  logic [1:0]  byte_offset_i,
  input  logic [31:0] data_in_i,
  input  logic        data_in_valid_i,
  output logic        write_o,
  output logic [3:0]  write_index_o,
  output logic [31:0] write_data_o,
  output logic [31:0] outbound_instruction_o,
  output logic        outbound_valid_o,
  output logic        fault_o,
  output logic [1:0]  fault_cause_o
);

  localparam logic [TIMEOUT_WIDTH-1:0] COUNT_LAST = TIMEOUT_WIDTH'(TIMEOUT_CYCLES - 1);

  t_wb_state                state_q, state_d;
  logic [TIMEOUT_WIDTH-1:0] count_q, count_d;
  logic [31:0]              pend_instr_q, pend_instr_d;
  logic [1:0]               pend_off_q, pend_off_d;
  logic                     write_q, write_d;
  t_reg                     index_q, index_d;
  logic [31:0]              data_q, data_d;
  logic [31:0]              out_instr_q, out_instr_d;
  logic                     out_valid_q, out_valid_d;
  logic                     fault_q, fault_d;
  t_wb_fault                cause_q, cause_d;

  logic [31:0] cur_instr;
  logic [1:0]  cur_off;
  logic [31:0] load_value;
  logic        load_misaligned;

  // While waiting, the aligner works on the captured load, not the live input.
  assign cur_instr = (state_q == ST_WAIT_DATA) ? pend_instr_q : inbound_instruction_i;
  assign cur_off   = (state_q == ST_WAIT_DATA) ? pend_off_q   : byte_offset_i;

  load_align_extend #(
    .ALIGN_LOADS(ALIGN_LOADS)
  ) u_align (
    .data_i       (data_in_i),
    .width_i      (cur_instr[26:25]),
    .signed_i     (cur_instr[24]),
    .byte_offset_i(cur_off),
    .value_o      (load_value),
    .misaligned_o (load_misaligned)
  );

  assign in_ready_o = (state_q == ST_RUN);

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    pend_instr_d = pend_instr_q;
    pend_off_d   = pend_off_q;
    write_d      = 1'b0;
    index_d      = '0;
    data_d       = 32'h0;
    out_instr_d  = NOP_INSTRUCTION;
    out_valid_d  = 1'b0;
    fault_d      = 1'b0;
    cause_d      = WB_FAULT_NONE;

    case (state_q)
      ST_RUN: begin
        if (in_valid_i) begin
          out_instr_d = cur_instr;
          out_valid_d = 1'b1;
          case (t_opcode'(cur_instr[31:27]))
            OPCODE_LOADI: begin
              if (cur_instr[25:24] == IT_RESERVED) begin
                fault_d = 1'b1;
                cause_d = WB_FAULT_BAD_IMM;
              end else begin
                write_d = 1'b1;
                index_d = cur_instr[23:20];
                data_d  = resolve_immediate(cur_instr[25:24], cur_instr[15:0]);
              end
            end
            OPCODE_LOAD: begin
              if (load_misaligned) begin
                fault_d = 1'b1;
                cause_d = WB_FAULT_MISALIGNED;
              end else if (data_in_valid_i) begin
                write_d = 1'b1;
                index_d = cur_instr[23:20];
                data_d  = load_value;
              end else begin
                out_instr_d  = NOP_INSTRUCTION;
                out_valid_d  = 1'b0;
                pend_instr_d = cur_instr;
                pend_off_d   = cur_off;
                count_d      = '0;
                state_d      = ST_WAIT_DATA;
              end
            end
            default: ;
          endcase
        end
      end

      ST_WAIT_DATA: begin
        // Data on the expiry cycle is checked first, so it wins over timeout.
        if (data_in_valid_i) begin
          write_d     = 1'b1;
          index_d     = cur_instr[23:20];
          data_d      = load_value;
          out_instr_d = cur_instr;
          out_valid_d = 1'b1;
          state_d     = ST_RUN;
        end else if (count_q == COUNT_LAST) begin
          fault_d     = 1'b1;
          cause_d     = WB_FAULT_TIMEOUT;
          out_instr_d = cur_instr;
          out_valid_d = 1'b1;
          state_d     = ST_RUN;
        end else begin
          count_d = count_q + 1'b1;
        end
      end

      default: state_d = ST_RUN;
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q      <= ST_RUN;
      count_q      <= '0;
      pend_instr_q <= NOP_INSTRUCTION;
      pend_off_q   <= 2'd0;
      write_q      <= 1'b0;
      index_q      <= '0;
      data_q       <= 32'h0;
      out_instr_q  <= NOP_INSTRUCTION;
      out_valid_q  <= 1'b0;
      fault_q      <= 1'b0;
      cause_q      <= WB_FAULT_NONE;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      pend_instr_q <= pend_instr_d;
      pend_off_q   <= pend_off_d;
      write_q      <= write_d;
      index_q      <= index_d;
      data_q       <= data_d;
      out_instr_q  <= out_instr_d;
      out_valid_q  <= out_valid_d;
      fault_q      <= fault_d;
      cause_q      <= cause_d;
    end
  end

  assign write_o                = write_q;
  assign write_index_o          = index_q;
  assign write_data_o           = data_q;
  assign outbound_instruction_o = out_instr_q;
  assign outbound_valid_o       = out_valid_q;
  assign fault_o                = fault_q;
  assign fault_cause_o          = cause_q;

endmodule

// File: tb/tb_writeback_stage_aligned.sv
// Scoreboard bench: the driver queues hand-computed retire records, a negedge
// monitor pops one whenever the stage writes, faults or retires.
module tb_writeback_stage_aligned;

  localparam logic [4:0]  OP_NOP = 5'h00, OP_LOAD = 5'h01, OP_LOADI = 5'h03, OP_ADD = 5'h04;
  localparam logic [31:0] NOP_I  = 32'h0000_0000;

  typedef struct packed {
    logic        write;
    logic [3:0]  idx;
    logic [31:0] data;
    logic [31:0] instr;
    logic        fault;
    logic [1:0]  cause;
  } exp_t;

  logic        clock_i = 1'b0;
  logic        reset_ni = 1'b1;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] inbound_instruction_i = 32'h0;
  logic [1:0]  byte_offset_i = 2'd0;
  logic [31:0] data_in_i = 32'h0;
  logic        data_in_valid_i = 1'b0;
  logic        write_o;
  logic [3:0]  write_index_o;
  logic [31:0] write_data_o;
  logic [31:0] outbound_instruction_o;
  logic        outbound_valid_o;
  logic        fault_o;
  logic [1:0]  fault_cause_o;

  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  writeback_stage_aligned #(
    .TIMEOUT_CYCLES(4),
    .TIMEOUT_WIDTH (8),
    .ALIGN_LOADS   (1)
  ) dut (
    .clock_i               (clock_i),
    .reset_ni              (reset_ni),
    .in_valid_i            (in_valid_i),
    .in_ready_o            (in_ready_o),
    .inbound_instruction_i (inbound_instruction_i),
    .byte_offset_i         (byte_offset_i),
    .data_in_i             (data_in_i),
    .data_in_valid_i       (data_in_valid_i),
    .write_o               (write_o),
    .write_index_o         (write_index_o),
    .write_data_o          (write_data_o),
    .outbound_instruction_o(outbound_instruction_o),
    .outbound_valid_o      (outbound_valid_o),
    .fault_o               (fault_o),
    .fault_cause_o         (fault_cause_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [31:0] mk_loadi(input logic [1:0] it, input logic [3:0] rd,
                                           input logic [15:0] imm);
    return {OP_LOADI, 1'b0, it, rd, 4'h0, imm};
  endfunction

  function automatic logic [31:0] mk_load(input logic [1:0] cw, input logic sgn,
                                          input logic [3:0] rd);
    return {OP_LOAD, cw, sgn, rd, 20'h0};
  endfunction

  task automatic drive(input logic v, input logic [31:0] instr, input logic [1:0] off,
                       input logic [31:0] data, input logic dv);
    in_valid_i            = v;
    inbound_instruction_i = instr;
    byte_offset_i         = off;
    data_in_i             = data;
    data_in_valid_i       = dv;
    @(posedge clock_i);
    #1;
  endtask

  task automatic push(input logic w, input logic [3:0] idx, input logic [31:0] data,
                      input logic [31:0] instr, input logic f, input logic [1:0] cause);
    exp_t e;
    e = '{write: w, idx: idx, data: data, instr: instr, fault: f, cause: cause};
    sb.push_back(e);
  endtask

  task automatic check_ready(input logic exp, input string name);
    checks++;
    if (in_ready_o !== exp) begin
      errors++;
      $display("FAIL %s: in_ready=%b required %b", name, in_ready_o, exp);
    end
  endtask

  task automatic check_reset_outputs(input string name);
    checks++;
    if (write_o !== 1'b0 || write_index_o !== 4'h0 || write_data_o !== 32'h0 ||
        outbound_instruction_o !== NOP_I || outbound_valid_o !== 1'b0 ||
        fault_o !== 1'b0 || fault_cause_o !== 2'd0 || in_ready_o !== 1'b1) begin
      errors++;
      $display("FAIL %s: w=%b idx=%h data=%h instr=%h ov=%b f=%b c=%0d rdy=%b required all reset values",
               name, write_o, write_index_o, write_data_o, outbound_instruction_o,
               outbound_valid_o, fault_o, fault_cause_o, in_ready_o);
    end
  endtask

  always @(negedge clock_i) begin
    if (reset_ni && (write_o || fault_o || outbound_valid_o)) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL spurious_output: w=%b idx=%h data=%h instr=%h f=%b c=%0d required no output",
                 write_o, write_index_o, write_data_o, outbound_instruction_o, fault_o, fault_cause_o);
      end else begin
        exp_t e;
        e = sb.pop_front();
        if (write_o !== e.write || write_index_o !== e.idx || write_data_o !== e.data ||
            outbound_instruction_o !== e.instr || outbound_valid_o !== 1'b1 ||
            fault_o !== e.fault || fault_cause_o !== e.cause) begin
          errors++;
          $display("FAIL retire: got w=%b idx=%h data=%h instr=%h ov=%b f=%b c=%0d required w=%b idx=%h data=%h instr=%h ov=1 f=%b c=%0d",
                   write_o, write_index_o, write_data_o, outbound_instruction_o, outbound_valid_o,
                   fault_o, fault_cause_o, e.write, e.idx, e.data, e.instr, e.fault, e.cause);
        end else begin
          $display("txn instr=%h write=%b idx=%0d data=%h fault=%b cause=%0d",
                   e.instr, e.write, e.idx, e.data, e.fault, e.cause);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] i_add, i_r7, i_r8, i_r9;
    i_add = {OP_ADD, 27'h0123456};
    i_r7  = mk_load(2'd2, 1'b0, 4'd7);
    i_r8  = mk_load(2'd2, 1'b0, 4'd8);
    i_r9  = mk_load(2'd2, 1'b0, 4'd9);

    #2 reset_ni = 1'b0;
    #1 check_reset_outputs("reset_state");
    @(posedge clock_i); @(posedge clock_i);
    @(negedge clock_i) reset_ni = 1'b1;
    @(posedge clock_i); #1;

    // LOADI variants
    push(1, 4'd3, 32'hFFFF_8001, mk_loadi(2'd1, 4'd3, 16'h8001), 0, 2'd0);
    drive(1, mk_loadi(2'd1, 4'd3, 16'h8001), 2'd0, 32'h0, 1'b0);
    push(1, 4'd1, 32'h0000_8001, mk_loadi(2'd0, 4'd1, 16'h8001), 0, 2'd0);
    drive(1, mk_loadi(2'd0, 4'd1, 16'h8001), 2'd0, 32'h0, 1'b0);
    push(1, 4'd2, 32'h1234_0000, mk_loadi(2'd2, 4'd2, 16'h1234), 0, 2'd0);
    drive(1, mk_loadi(2'd2, 4'd2, 16'h1234), 2'd0, 32'h0, 1'b0);
    push(0, 4'd0, 32'h0, mk_loadi(2'd3, 4'd4, 16'h5555), 1, 2'd3);
    drive(1, mk_loadi(2'd3, 4'd4, 16'h5555), 2'd0, 32'h0, 1'b0);

    // Immediate loads with data present
    push(1, 4'd5, 32'hFFFF_FFAB, mk_load(2'd0, 1'b1, 4'd5), 0, 2'd0);
    drive(1, mk_load(2'd0, 1'b1, 4'd5), 2'd2, 32'h00AB_0000, 1'b1);
    push(1, 4'd6, 32'h0000_0080, mk_load(2'd0, 1'b0, 4'd6), 0, 2'd0);
    drive(1, mk_load(2'd0, 1'b0, 4'd6), 2'd3, 32'h8000_0000, 1'b1);
    push(1, 4'd10, 32'hFFFF_8765, mk_load(2'd1, 1'b1, 4'd10), 0, 2'd0);
    drive(1, mk_load(2'd1, 1'b1, 4'd10), 2'd2, 32'h8765_0000, 1'b1);
    push(1, 4'd11, 32'h0000_ABCD, mk_load(2'd1, 1'b0, 4'd11), 0, 2'd0);
    drive(1, mk_load(2'd1, 1'b0, 4'd11), 2'd0, 32'h1234_ABCD, 1'b1);
    push(1, 4'd12, 32'hCAFE_F00D, mk_load(2'd3, 1'b1, 4'd12), 0, 2'd0);
    drive(1, mk_load(2'd3, 1'b1, 4'd12), 2'd0, 32'hCAFE_F00D, 1'b1);

    // Misaligned loads fault at accept, even with no data, and enter no wait
    push(0, 4'd0, 32'h0, mk_load(2'd1, 1'b0, 4'd13), 1, 2'd1);
    drive(1, mk_load(2'd1, 1'b0, 4'd13), 2'd1, 32'h0, 1'b0);
    check_ready(1'b1, "ready_after_word_misalign");
    push(0, 4'd0, 32'h0, mk_load(2'd2, 1'b0, 4'd14), 1, 2'd1);
    drive(1, mk_load(2'd2, 1'b0, 4'd14), 2'd2, 32'hFFFF_FFFF, 1'b1);

    // Non-load forwarding, then stray data with nothing pending
    push(0, 4'd0, 32'h0, i_add, 0, 2'd0);
    drive(1, i_add, 2'd0, 32'h0, 1'b0);
    drive(0, i_add, 2'd0, 32'h5A5A_5A5A, 1'b1);
    drive(0, NOP_I, 2'd0, 32'h0, 1'b0);

    // Slow LONG load; in_valid held high during the wait must be ignored
    drive(1, i_r7, 2'd0, 32'h0, 1'b0);
    check_ready(1'b0, "wait_ready_1");
    drive(1, i_add, 2'd0, 32'h0, 1'b0);
    check_ready(1'b0, "wait_ready_2");
    drive(1, i_add, 2'd0, 32'h0, 1'b0);
    check_ready(1'b0, "wait_ready_3");
    push(1, 4'd7, 32'hDEAD_BEEF, i_r7, 0, 2'd0);
    drive(1, i_add, 2'd0, 32'hDEAD_BEEF, 1'b1);
    check_ready(1'b1, "ready_after_data");
    drive(0, NOP_I, 2'd0, 32'h0, 1'b0);

    // Timeout after four wait cycles
    drive(1, i_r8, 2'd0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) drive(0, NOP_I, 2'd0, 32'h0, 1'b0);
    check_ready(1'b0, "ready_last_wait_cycle");
    push(0, 4'd0, 32'h0, i_r8, 1, 2'd2);
    drive(0, NOP_I, 2'd0, 32'h0, 1'b0);
    check_ready(1'b1, "ready_after_timeout");

    // Data on the expiry cycle wins
    drive(1, i_r9, 2'd0, 32'h0, 1'b0);
    for (int k = 0; k < 3; k++) drive(0, NOP_I, 2'd0, 32'h0, 1'b0);
    push(1, 4'd9, 32'h1122_3344, i_r9, 0, 2'd0);
    drive(0, NOP_I, 2'd0, 32'h1122_3344, 1'b1);
    drive(0, NOP_I, 2'd0, 32'h0, 1'b0);

    // Reset while waiting abandons the load
    push(1, 4'd1, 32'h0000_0042, mk_loadi(2'd0, 4'd1, 16'h0042), 0, 2'd0);
    drive(1, mk_loadi(2'd0, 4'd1, 16'h0042), 2'd0, 32'h0, 1'b0);
    drive(1, i_r7, 2'd0, 32'h0, 1'b0);
    check_ready(1'b0, "ready_before_reset");
    in_valid_i = 1'b0;
    #2 reset_ni = 1'b0;
    #1 check_reset_outputs("reset_mid_wait");
    @(posedge clock_i);
    @(negedge clock_i) reset_ni = 1'b1;
    @(posedge clock_i); #1;
    for (int k = 0; k < 3; k++) drive(0, NOP_I, 2'd0, 32'h7777_7777, 1'b1);
    drive(0, NOP_I, 2'd0, 32'h0, 1'b0);
    drive(0, NOP_I, 2'd0, 32'h0, 1'b0);

    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d expected records left, required 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/writeback_stage_aligned.md
Name: writeback_stage_aligned

Overview:
Parametrised successor to the stage-2 writeback register stage of the maxicore32 pipeline; sits after the memory-access stage and drives the register-file write port.
- Resolves LOADI immediates to a full 32-bit value internally, so the register file sees one write path.
- Aligns and extends sub-word loads by address byte offset.
- Waits, with timeout, for slow memory data using a valid/ready handshake; raises precise faults for misaligned or timed-out loads.

Parameters:
TIMEOUT_CYCLES, 255, max cycles spent in WAIT_DATA before a timeout fault (1..2^TIMEOUT_WIDTH-1)
TIMEOUT_WIDTH, 8, width of wait counter
ALIGN_LOADS, 1, 1 = lane-select by byte_offset; 0 = legacy (always low lanes, no misalign check)

Ports:
clock  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset
in_valid  in  1  inbound_instruction/byte_offset valid this cycle
in_ready  out  1  stage can accept; combinational, low only in WAIT_DATA
inbound_instruction  in  32  instruction from previous stage
byte_offset  in  2  address[1:0] of the load
data_in  in  32  memory read data
data_in_valid  in  1  data_in valid this cycle
write  out  1  register write strobe (one cycle per instruction)
write_index  out  4  destination register
write_data  out  32  fully resolved value (load or immediate)
outbound_instruction  out  32  instruction forwarded to hazard/forwarding logic
outbound_valid  out  1  outbound_instruction is a retired instruction
fault  out  1  one-cycle fault pulse
fault_cause  out  2  0 none, 1 misaligned, 2 timeout, 3 reserved-immediate

Behaviour:
- Reset (reset low, async): state RUN, counter 0, write 0, write_index 0, write_data 0, outbound_instruction {OPCODE_NOP,27'h0}, outbound_valid 0, fault 0, fault_cause 0.
- All outputs registered except in_ready; latency 1 cycle from accept (or from data_in_valid in WAIT_DATA).
- Fields: opcode [31:27]; CW width [26:25]; signed [24] (LOAD); immediate type [25:24] (LOADI); reg [23:20]; imm [15:0].
- RUN, in_valid=0: write 0, fault 0, outbound_valid 0, outbound_instruction NOP.
- RUN, LOADI: write 1; IT_UNSIGNED zero-extend imm; IT_SIGNED sign-extend imm[15]; IT_TOP {imm,16'h0}; encoding 3 → write 0, fault cause 3.
- RUN, LOAD, data_in_valid=1: align+extend, write 1 next edge.
- RUN, LOAD, data_in_valid=0: capture instruction/offset, counter 0, → WAIT_DATA; write 0, outbound_valid 0.
- Other opcodes: write 0, forwarded with outbound_valid 1.
- WAIT_DATA: in_ready 0, in_valid ignored; counter++ each cycle; data_in_valid → write with captured instruction, → RUN. Counter reaching TIMEOUT_CYCLES without data → write 0, fault cause 2, outbound_valid 1, → RUN. Data on the same cycle as expiry: data wins, no fault.
- Alignment (ALIGN_LOADS=1): BYTE lane = data_in[8*off+7 : 8*off]; WORD needs off∈{0,2}, lane = data_in[8*off+15 : 8*off]; LONG needs off=0. Violation → write 0, fault cause 1, checked at accept (no wait entered). Undefined CW encoding treated as LONG.
- Extension: signed bit → replicate lane MSB to 32; else zero-fill.
- Faulted instructions still forward with outbound_valid 1.
- data_in_valid when no load is pending: ignored.
- Reset mid-WAIT_DATA: pending load abandoned, no write, no fault.

Decomposition:
- opcodes.vh / registers.vh: OPCODE_*, t_opcode, CW_BYTE/CW_WORD/CW_LONG, t_immediate_type (add IT_TOP), t_reg.
- New shared enum t_wb_fault (NONE, MISALIGNED, TIMEOUT, BAD_IMM) in registers.vh.
- One sub-module: load_align_extend (combinational lane select + sign/zero extend + misalign detect), reused by forwarding logic.
- FSM (RUN/WAIT_DATA) and timeout counter stay in this module.

Test Plan:
- LOADI IT_SIGNED r3 imm 16'h8001 → next cycle write 1, write_index 3, write_data 32'hFFFF8001.
- LOAD BYTE signed r5, off 2, data_in 32'h00AB0000, data valid → write_data 32'hFFFFFFAB, index 5, one cycle later.
- LOAD WORD off 1 → write 0, fault 1, fault_cause 1, outbound_valid 1, no WAIT entry.
- LOAD LONG r7, data_in_valid low 3 cycles then data 32'hDEADBEEF → in_ready 0 three cycles, write_data 32'hDEADBEEF on the edge after data_in_valid.
- LOAD with data never valid, TIMEOUT_CYCLES=4 → fault_cause 2 after 4 wait cycles, write 0, in_ready high again; repeat with data on expiry cycle → write, no fault.
- Assert reset low during WAIT_DATA → all outputs at reset values immediately, no write after release.
